axi4_lite_arb_master: RTL and testbench

//  Two-requester AXI4-Lite master. Arbitrates simple request ports onto a single AXI4-Lite

---
 rtl/axi4_lite_arb_pkg.sv | 18 +
 rtl/axi4_lite_arb_master_if.sv | 38 +++
 rtl/axi4_lite_arb_master_rr_arb2.sv | 18 +
 rtl/axi4_lite_arb_master.sv | 172 +++++++++++++++++
 tb/tb_axi4_lite_arb_master.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_arb_pkg.sv
// Shared encodings for the two-requester AXI4-Lite arbitrating master.
// The state encoding is 3 bits wide; values 6 and 7 are unused and recover to IDLE.
package axi4_lite_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WSTRB_ALL   = 4'hF;

endpackage

// File: rtl/axi4_lite_arb_master_if.sv
// AXI4-Lite bus between the arbitrating master and a single slave.
// Every channel transfers on a cycle where VALID and READY are both high; VALID never waits on READY and payload is stable while VALID is high.
interface axi4_lite_arb_master_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDRESS-1:0]    M_AWADDR;
    logic                  M_AWVALID;
    logic                  M_AWREADY;
    logic [DATA_WIDTH-1:0] M_WDATA;
    logic [3:0]            M_WSTRB;
    logic                  M_WVALID;
    logic                  M_WREADY;
    logic [1:0]            M_BRESP;
    logic                  M_BVALID;
    logic                  M_BREADY;
    logic [ADDRESS-1:0]    M_ARADDR;
    logic                  M_ARVALID;
    logic                  M_ARREADY;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;
    logic                  M_RVALID;
    logic                  M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
        output M_ARADDR, M_ARVALID, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
        input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
        input  M_ARADDR, M_ARVALID, M_RREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
        output M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );
endinterface

// File: rtl/axi4_lite_arb_master_rr_arb2.sv
// Combinational two-way grant: round-robin on a tie by default,
// fixed priority to requester 0 when AXI_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);
`ifdef AXI_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = ~req[0];
`else
    // Tie goes to whoever did not win last; a lone requester always wins.
    assign grant = (req == 2'b11) ? ~last_grant : req[1];
`endif
    assign any_req = |req;
endmodule

// File: rtl/axi4_lite_arb_master.sv
// Two-requester AXI4-Lite master: one full transaction at a time (AW+W+B or AR+R).
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority to REQ0 instead of round-robin.
module axi4_lite_arb_master
    import axi4_lite_arb_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  REQ0_VALID,
    input  logic                  REQ0_WRITE,
    input  logic [ADDRESS-1:0]    REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
    output logic                  REQ0_DONE,
    output logic [DATA_WIDTH-1:0] REQ0_RDATA,
    output logic [1:0]            REQ0_RESP,
    input  logic                  REQ1_VALID,
    input  logic                  REQ1_WRITE,
    input  logic [ADDRESS-1:0]    REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
    output logic                  REQ1_DONE,
    output logic [DATA_WIDTH-1:0] REQ1_RDATA,
    output logic [1:0]            REQ1_RESP,
    axi4_lite_arb_master_if.master m_axi,
    output arb_state_t            dbg_state
);

    arb_state_t state;
    logic       last_grant;
    logic       gnt;
    logic       aw_done;
    logic       w_done;

    logic       arb_grant;
    logic       any_req;
    logic       win_write;
    logic [ADDRESS-1:0]    win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    rr_arb2 u_arb (
        .req        ({REQ1_VALID, REQ0_VALID}),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    assign win_write = arb_grant ? REQ1_WRITE : REQ0_WRITE;
    assign win_addr  = arb_grant ? REQ1_ADDR  : REQ0_ADDR;
    assign win_wdata = arb_grant ? REQ1_WDATA : REQ0_WDATA;

    logic aw_hs;
    logic w_hs;
    assign aw_hs = m_axi.M_AWVALID && m_axi.M_AWREADY;
    assign w_hs  = m_axi.M_WVALID  && m_axi.M_WREADY;

    assign dbg_state = state;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state           <= ST_IDLE;
            last_grant      <= 1'b1;
            gnt             <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            m_axi.M_AWADDR  <= '0;
            m_axi.M_AWVALID <= 1'b0;
            m_axi.M_WDATA   <= '0;
            m_axi.M_WSTRB   <= '0;
            m_axi.M_WVALID  <= 1'b0;
            m_axi.M_BREADY  <= 1'b0;
            m_axi.M_ARADDR  <= '0;
            m_axi.M_ARVALID <= 1'b0;
            m_axi.M_RREADY  <= 1'b0;
            REQ0_DONE       <= 1'b0;
            REQ0_RDATA      <= '0;
            REQ0_RESP       <= RESP_OKAY;
            REQ1_DONE       <= 1'b0;
            REQ1_RDATA      <= '0;
            REQ1_RESP       <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt        <= arb_grant;
                        last_grant <= arb_grant;
                        if (win_write) begin
                            m_axi.M_AWADDR  <= win_addr;
                            m_axi.M_WDATA   <= win_wdata;
                            m_axi.M_WSTRB   <= WSTRB_ALL;
                            m_axi.M_AWVALID <= 1'b1;
                            m_axi.M_WVALID  <= 1'b1;
                            aw_done         <= 1'b0;
                            w_done          <= 1'b0;
                            state           <= ST_WRITE;
                        end else begin
                            m_axi.M_ARADDR  <= win_addr;
                            m_axi.M_ARVALID <= 1'b1;
                            state           <= ST_RADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    // AW and W retire independently; either may finish first.
                    if (aw_hs) begin
                        m_axi.M_AWVALID <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi.M_WVALID <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi.M_BREADY <= 1'b1;
                        state          <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m_axi.M_BVALID) begin
                        m_axi.M_BREADY <= 1'b0;
                        if (gnt) begin
                            REQ1_RESP <= m_axi.M_BRESP;
                            REQ1_DONE <= 1'b1;
                        end else begin
                            REQ0_RESP <= m_axi.M_BRESP;
                            REQ0_DONE <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_RADDR: begin
                    if (m_axi.M_ARREADY) begin
                        m_axi.M_ARVALID <= 1'b0;
                        m_axi.M_RREADY  <= 1'b1;
                        state           <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_axi.M_RVALID) begin
                        m_axi.M_RREADY <= 1'b0;
                        if (gnt) begin
                            REQ1_RDATA <= m_axi.M_RDATA;
                            REQ1_RESP  <= m_axi.M_RRESP;
                            REQ1_DONE  <= 1'b1;
                        end else begin
                            REQ0_RDATA <= m_axi.M_RDATA;
                            REQ0_RESP  <= m_axi.M_RRESP;
                            REQ0_DONE  <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    REQ0_DONE <= 1'b0;
                    REQ1_DONE <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    m_axi.M_AWVALID <= 1'b0;
                    m_axi.M_WVALID  <= 1'b0;
                    m_axi.M_BREADY  <= 1'b0;
                    m_axi.M_ARVALID <= 1'b0;
                    m_axi.M_RREADY  <= 1'b0;
                    REQ0_DONE       <= 1'b0;
                    REQ1_DONE       <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_arb_master.sv
// Directed bench for axi4_lite_arb_master against a small register-file slave model.
module tb_axi4_lite_arb_master;
    import axi4_lite_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // clock / reset
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic          REQ0_VALID, REQ0_WRITE, REQ0_DONE;
    logic [AW-1:0] REQ0_ADDR;
    logic [DW-1:0] REQ0_WDATA, REQ0_RDATA;
    logic [1:0]    REQ0_RESP;
    logic          REQ1_VALID, REQ1_WRITE, REQ1_DONE;
    logic [AW-1:0] REQ1_ADDR;
    logic [DW-1:0] REQ1_WDATA, REQ1_RDATA;
    logic [1:0]    REQ1_RESP;
    arb_state_t    dbg_state;

    axi4_lite_arb_master_if #(.ADDRESS(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_arb_master #(.ADDRESS(AW), .DATA_WIDTH(DW)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_WRITE (REQ0_WRITE),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_WDATA (REQ0_WDATA),
        .REQ0_DONE  (REQ0_DONE),
        .REQ0_RDATA (REQ0_RDATA),
        .REQ0_RESP  (REQ0_RESP),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_WRITE (REQ1_WRITE),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_WDATA (REQ1_WDATA),
        .REQ1_DONE  (REQ1_DONE),
        .REQ1_RDATA (REQ1_RDATA),
        .REQ1_RESP  (REQ1_RESP),
        .m_axi      (bus),
        .dbg_state  (dbg_state)
    );

    // slave model: 32 word registers, configurable AWREADY stall, programmable responses
    int          cfg_aw_stall = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] mem [0:31] = '{default: 32'h0};
    int          aw_cnt;
    logic        got_aw, got_w;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;
    logic [3:0]    last_wstrb;

    assign bus.M_AWREADY = (aw_cnt >= cfg_aw_stall);
    assign bus.M_WREADY  = 1'b1;
    assign bus.M_ARREADY = 1'b1;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt       <= 0;
            got_aw       <= 1'b0;
            got_w        <= 1'b0;
            bus.M_BVALID <= 1'b0;
            bus.M_BRESP  <= 2'b00;
            bus.M_RVALID <= 1'b0;
            bus.M_RDATA  <= '0;
            bus.M_RRESP  <= 2'b00;
        end else begin
            if (bus.M_AWVALID && !bus.M_AWREADY) aw_cnt <= aw_cnt + 1;
            if (bus.M_AWVALID && bus.M_AWREADY) begin
                aw_cnt      <= 0;
                got_aw      <= 1'b1;
                last_awaddr <= bus.M_AWADDR;
            end
            if (bus.M_WVALID && bus.M_WREADY) begin
                got_w      <= 1'b1;
                last_wdata <= bus.M_WDATA;
                last_wstrb <= bus.M_WSTRB;
            end
            if (!bus.M_BVALID && (got_aw || (bus.M_AWVALID && bus.M_AWREADY))
                              && (got_w  || (bus.M_WVALID  && bus.M_WREADY))) begin
                bus.M_BVALID <= 1'b1;
                bus.M_BRESP  <= cfg_bresp;
                if (got_aw)
                    mem[last_awaddr[6:2]] <= got_w ? last_wdata : bus.M_WDATA;
                else
                    mem[bus.M_AWADDR[6:2]] <= got_w ? last_wdata : bus.M_WDATA;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end
            if (bus.M_BVALID && bus.M_BREADY) bus.M_BVALID <= 1'b0;
            if (bus.M_ARVALID && bus.M_ARREADY) begin
                last_araddr  <= bus.M_ARADDR;
                bus.M_RVALID <= 1'b1;
                bus.M_RDATA  <= mem[bus.M_ARADDR[6:2]];
                bus.M_RRESP  <= cfg_rresp;
            end
            if (bus.M_RVALID && bus.M_RREADY) bus.M_RVALID <= 1'b0;
        end
    end

    // mid-cycle monitors
    int done0_cnt = 0, done1_cnt = 0, awv_cyc = 0, wv_cyc = 0, aw_hs_cnt = 0;
    always @(negedge ACLK) begin
        if (REQ0_DONE) done0_cnt <= done0_cnt + 1;
        if (REQ1_DONE) done1_cnt <= done1_cnt + 1;
        if (bus.M_AWVALID) awv_cyc <= awv_cyc + 1;
        if (bus.M_WVALID) wv_cyc <= wv_cyc + 1;
        if (bus.M_AWVALID && bus.M_AWREADY) aw_hs_cnt <= aw_hs_cnt + 1;
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    logic [0:0] act_q[$];
    logic [DW-1:0] mdl_rdata [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver
    task automatic do_req(input int id, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output logic [1:0] resp, output logic done_seen);
        done_seen = 1'b0;
        rdata = '0;
        resp = 2'b00;
        @(negedge ACLK);
        if (id == 0) begin
            REQ0_VALID = 1'b1; REQ0_WRITE = wr; REQ0_ADDR = addr; REQ0_WDATA = wdata;
        end else begin
            REQ1_VALID = 1'b1; REQ1_WRITE = wr; REQ1_ADDR = addr; REQ1_WDATA = wdata;
        end
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge ACLK);
            if ((id == 0 && REQ0_DONE) || (id == 1 && REQ1_DONE)) begin
                done_seen = 1'b1;
                rdata = (id == 0) ? REQ0_RDATA : REQ1_RDATA;
                resp  = (id == 0) ? REQ0_RESP  : REQ1_RESP;
            end
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input string tag);
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        logic          ok;
        int            b0, b1;
        cfg_bresp = v.bresp;
        cfg_rresp = v.rresp;
        b0 = done0_cnt;
        b1 = done1_cnt;
        do_req(v.id, v.wr, v.addr, v.wdata, rd, rs, ok);
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        if (v.wr) begin
            check({tag, "_awaddr"}, 64'(last_awaddr), 64'(v.addr));
            check({tag, "_wdata"}, 64'(last_wdata), 64'(v.wdata));
            check({tag, "_wstrb"}, 64'(last_wstrb), 64'hF);
        end else begin
            check({tag, "_araddr"}, 64'(last_araddr), 64'(v.addr));
            mdl_rdata[v.id] = v.exp_rdata;
        end
        check({tag, "_rdata"}, 64'(rd), 64'(mdl_rdata[v.id]));
        check({tag, "_resp"}, 64'(rs), 64'(v.exp_resp));
        repeat (2) @(negedge ACLK);
        check({tag, "_other_rdata"}, 64'(v.id == 0 ? REQ1_RDATA : REQ0_RDATA), 64'(mdl_rdata[1 - v.id]));
        check({tag, "_own_done_pulses"}, 64'(v.id == 0 ? done0_cnt - b0 : done1_cnt - b1), 64'd1);
        check({tag, "_other_done_pulses"}, 64'(v.id == 0 ? done1_cnt - b1 : done0_cnt - b0), 64'd0);
        check({tag, "_idle"}, 64'(dbg_state), 64'(ST_IDLE));
        cfg_bresp = 2'b00;
        cfg_rresp = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        logic          ok;
        int            a0, w0, h0, b1, n;

        vecs[0] = '{0, 1'b1, 32'h08, 32'h0000_1234, 2'b00, 2'b00, 32'h0, 2'b00};
        vecs[1] = '{1, 1'b0, 32'h08, 32'h0,         2'b00, 2'b00, 32'h0000_1234, 2'b00};
        vecs[2] = '{1, 1'b1, 32'h7C, 32'hDEAD_BEEF, 2'b00, 2'b00, 32'h0, 2'b00};
        vecs[3] = '{0, 1'b0, 32'h7C, 32'h0,         2'b00, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{0, 1'b1, 32'h10, 32'h0000_A5A5, 2'b10, 2'b00, 32'h0, 2'b10};
        vecs[5] = '{1, 1'b0, 32'h00, 32'h0,         2'b00, 2'b00, 32'h0, 2'b00};
        vecs[6] = '{0, 1'b0, 32'h08, 32'h0,         2'b00, 2'b10, 32'h0000_1234, 2'b10};
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;

        REQ0_VALID = 1'b0; REQ0_WRITE = 1'b0; REQ0_ADDR = '0; REQ0_WDATA = '0;
        REQ1_VALID = 1'b0; REQ1_WRITE = 1'b0; REQ1_ADDR = '0; REQ1_WDATA = '0;

        // reset values
        repeat (3) @(negedge ACLK);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_valids", 64'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}), 64'd0);
        check("rst_readies", 64'({bus.M_BREADY, bus.M_RREADY}), 64'd0);
        check("rst_done", 64'({REQ0_DONE, REQ1_DONE}), 64'd0);
        check("rst_rdata", 64'({REQ0_RDATA, REQ1_RDATA}), 64'd0);
        check("rst_resp", 64'({REQ0_RESP, REQ1_RESP}), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // AWREADY held low for three cycles while WREADY stays high
        cfg_aw_stall = 3;
        a0 = awv_cyc; w0 = wv_cyc; h0 = aw_hs_cnt;
        do_req(0, 1'b1, 32'h20, 32'h0000_0055, rd, rs, ok);
        check("stall_done_seen", 64'(ok), 64'd1);
        check("stall_awvalid_cycles", 64'(awv_cyc - a0), 64'd4);
        check("stall_wvalid_cycles", 64'(wv_cyc - w0), 64'd1);
        check("stall_aw_handshakes", 64'(aw_hs_cnt - h0), 64'd1);
        check("stall_resp", 64'(rs), 64'd0);
        cfg_aw_stall = 0;
        do_req(1, 1'b0, 32'h20, 32'h0, rd, rs, ok);
        check("stall_readback", 64'(rd), 64'h55);
        mdl_rdata[1] = 32'h55;
        repeat (2) @(negedge ACLK);

        // both requesters valid continuously; last grant was REQ1
`ifdef AXI_ARB_FIXED_PRIO_EN
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        act_q.delete();
        @(negedge ACLK);
        REQ0_VALID = 1'b1; REQ0_WRITE = 1'b1; REQ0_ADDR = 32'h40; REQ0_WDATA = 32'h0000_0A0A;
        REQ1_VALID = 1'b1; REQ1_WRITE = 1'b1; REQ1_ADDR = 32'h44; REQ1_WDATA = 32'h0000_0B0B;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge ACLK);
            if (REQ0_DONE) begin act_q.push_back(1'b0); n++; end
            if (REQ1_DONE) begin act_q.push_back(1'b1); n++; end
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        check("rr_completions", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), 64'(i < act_q.size() ? act_q[i] : 1'bx), 64'(exp_q[i]));
        repeat (3) @(negedge ACLK);

        // reset while a read response is pending
        b1 = done1_cnt;
        REQ1_VALID = 1'b1; REQ1_WRITE = 1'b0; REQ1_ADDR = 32'h7C; REQ1_WDATA = '0;
        repeat (2) @(negedge ACLK);
        check("abort_in_rdata", 64'(dbg_state), 64'(ST_RDATA));
        check("abort_rvalid_pending", 64'(bus.M_RVALID), 64'd1);
        ARESETN = 1'b0;
        REQ1_VALID = 1'b0;
        #1;
        check("abort_valids", 64'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}), 64'd0);
        check("abort_readies", 64'({bus.M_BREADY, bus.M_RREADY}), 64'd0);
        check("abort_done", 64'({REQ0_DONE, REQ1_DONE}), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        check("abort_rdata_cleared", 64'({REQ0_RDATA, REQ1_RDATA}), 64'd0);
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("abort_no_done", 64'(done1_cnt - b1), 64'd0);
        do_req(1, 1'b0, 32'h7C, 32'h0, rd, rs, ok);
        check("post_reset_done_seen", 64'(ok), 64'd1);
        check("post_reset_rdata", 64'(rd), 64'hDEAD_BEEF);
        check("post_reset_resp", 64'(rs), 64'd0);
        check("post_reset_other_rdata", 64'(REQ0_RDATA), 64'd0);
        repeat (2) @(negedge ACLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
